// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch unit and its read buffer.
package fetch_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int TW_DEF = 2;

  typedef logic [TW_DEF-1:0] thread_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_buf.sv
// Per-thread one-entry read buffer (valid, addr, data); looked up by thread,
// filled by bus reads, invalidated by any write to a matching address.
module fetch_buf #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [TW-1:0] lookup_thread,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data,
  input  logic          fill_en,
  input  logic [TW-1:0] fill_thread,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          inval_en,
  input  logic [AW-1:0] inval_addr
);

  localparam int NT = 1 << TW;

  logic [NT-1:0] valid;
  logic [AW-1:0] tag [NT];
  logic [DW-1:0] dat [NT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (inval_en && tag[i] == inval_addr) valid[i] <= 1'b0;
      end
      if (fill_en) valid[fill_thread] <= 1'b1;
    end
  end

  // Payload carries no reset; it is only ever read behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag[fill_thread] <= fill_addr;
      dat[fill_thread] <= fill_data;
    end
  end

  assign hit      = valid[lookup_thread] && (tag[lookup_thread] == lookup_addr);
  assign hit_data = dat[lookup_thread];

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding CPU-to-bus access unit with thread-tagged ack.
// Define FETCH_BUF_EN to add the per-thread read buffer (fetch_buf).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_enable,
  input  logic          write_mode,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_i,
  input  logic [TW-1:0] thread,
  output logic [DW-1:0] data_o,
  output logic          ack,
  output logic [TW-1:0] ack_thread,
  output logic          w_req,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data_o,
  output logic          w_write,
  input  logic          w_ack,
  input  logic [DW-1:0] w_data_i
);

  state_t        state, next_state;
  logic          latch_en, bus_done, hit_take;
  logic          buf_hit;
  logic [DW-1:0] buf_data;
  logic [TW-1:0] thr_q;

`ifdef FETCH_BUF_EN
  fetch_buf #(.AW(AW), .DW(DW), .TW(TW)) u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_thread (thread),
    .lookup_addr   (addr),
    .hit           (buf_hit),
    .hit_data      (buf_data),
    .fill_en       (bus_done && !w_write),
    .fill_thread   (thr_q),
    .fill_addr     (w_addr),
    .fill_data     (w_data_i),
    .inval_en      (latch_en && write_mode),
    .inval_addr    (addr)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    next_state = state;
    latch_en   = 1'b0;
    bus_done   = 1'b0;
    hit_take   = 1'b0;
    unique case (state)
      IDLE: begin
        if (f_enable) begin
          latch_en = 1'b1;
          if (!write_mode && buf_hit) begin
            hit_take   = 1'b1;
            next_state = DONE;
          end else begin
            next_state = BUS;
          end
        end
      end
      BUS: begin
        if (w_ack) begin
          bus_done   = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The w_* registers double as the request latch; they stay put until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      data_o     <= '0;
      ack        <= 1'b0;
      ack_thread <= '0;
      w_req      <= 1'b0;
      w_addr     <= '0;
      w_data_o   <= '0;
      w_write    <= 1'b0;
      thr_q      <= '0;
    end else begin
      state <= next_state;
      ack   <= (next_state == DONE);
      w_req <= (next_state == BUS);
      if (latch_en) begin
        w_addr   <= addr;
        w_data_o <= data_i;
        w_write  <= write_mode;
        thr_q    <= thread;
      end
      if (bus_done && !w_write) data_o <= w_data_i;
      if (hit_take) data_o <= buf_data;
      if (next_state == DONE) ack_thread <= hit_take ? thread : thr_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, corner sequences, random vs. model.
module tb_fetch_unit;
  import fetch_pkg::*;

`ifdef FETCH_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_enable = 1'b0;
  logic        write_mode = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_i = '0;
  thread_t     thread = '0;
  logic [31:0] data_o;
  logic        ack;
  thread_t     ack_thread;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data_o;
  logic        w_write;
  logic        w_ack = 1'b0;
  logic [31:0] w_data_i = '0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_enable   (f_enable),
    .write_mode (write_mode),
    .addr       (addr),
    .data_i     (data_i),
    .thread     (thread),
    .data_o     (data_o),
    .ack        (ack),
    .ack_thread (ack_thread),
    .w_req      (w_req),
    .w_addr     (w_addr),
    .w_data_o   (w_data_o),
    .w_write    (w_write),
    .w_ack      (w_ack),
    .w_data_i   (w_data_i)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One request with a slave that acks on bus cycle waits+1; request inputs
  // are scrambled after the accept edge to prove they are ignored.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input int t, input int waits, input logic [31:0] rdata,
                         output int lat, output int busc, output bit stable,
                         output bit pulse_ok, output logic [31:0] got_do, output int got_thr);
    bit done;
    @(negedge clk);
    f_enable = 1'b1; write_mode = wr; addr = a; data_i = d; thread = thread_t'(t);
    lat = -1; busc = 0; stable = 1'b1; pulse_ok = 1'b0; got_do = '0; got_thr = -1; done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(posedge clk); #1;
      if (w_req) begin
        if (w_addr !== a || w_write !== wr || (wr && w_data_o !== d)) stable = 1'b0;
        w_ack    = (busc == waits);
        w_data_i = (busc == waits) ? rdata : 32'hBAD0_0000 + k;
        busc++;
      end else begin
        w_ack = 1'b0;
      end
      addr = a + 32'h200; data_i = ~d; write_mode = ~wr; thread = thread_t'(t + 1);
      if (ack) begin
        lat = k; got_do = data_o; got_thr = int'(ack_thread);
        f_enable = 1'b0; done = 1'b1;
      end
    end
    w_ack = 1'b0;
    f_enable = 1'b0;
    @(posedge clk); #1;
    pulse_ok = (ack === 1'b0 && w_req === 1'b0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          t;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] exp_do;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  // Reference model state: last read data and per-thread buffer contents.
  logic [31:0] md;
  bit          bv[4];
  logic [31:0] ba[4];
  logic [31:0] bd[4];

  initial begin
    int lat, busc, gthr, acks, rises, a1, a2, r2;
    bit st, po, prev, w, hitm;
    logic [31:0] gdo, a, d, rd;
    int t, wt, elat;

    vecs[0] = '{1'b0, 32'h100, 32'h0, 1, 0, 32'h1, 32'h1, 2};
    vecs[1] = '{1'b1, 32'h200, 32'hDEAD_BEEF, 0, 3, 32'h0, 32'h1, 5};
    vecs[2] = '{1'b0, 32'h100, 32'h0, 1, 1, 32'h11, BUF ? 32'h1 : 32'h11, BUF ? 1 : 3};
    vecs[3] = '{1'b0, 32'h100, 32'h0, 2, 0, 32'h22, 32'h22, 2};
    vecs[4] = '{1'b1, 32'h100, 32'h5, 0, 0, 32'h0, 32'h22, 2};
    vecs[5] = '{1'b0, 32'h100, 32'h0, 1, 2, 32'h33, 32'h33, 4};
    vecs[6] = '{1'b0, 32'h100, 32'h0, 1, 0, 32'h44, BUF ? 32'h33 : 32'h44, BUF ? 1 : 2};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 3, 5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 7};

    repeat (3) @(negedge clk);
    chk("reset_w_req", w_req, 0);
    chk("reset_ack", ack, 0);
    chk("reset_outs", {data_o, w_addr, w_data_o, w_write, ack_thread}, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].t, vecs[i].waits, vecs[i].rdata,
              lat, busc, st, po, gdo, gthr);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_buscycles", i), busc, (vecs[i].exp_lat == 1) ? 0 : vecs[i].waits + 1);
      chk($sformatf("vec%0d_stable", i), st, 1);
      chk($sformatf("vec%0d_pulse", i), po, 1);
      chk($sformatf("vec%0d_data_o", i), gdo, vecs[i].exp_do);
      chk($sformatf("vec%0d_ack_thread", i), gthr, vecs[i].t);
    end

    // Reset during BUS: bus cycle dropped asynchronously, no ack afterwards.
    @(negedge clk);
    f_enable = 1'b1; write_mode = 1'b0; addr = 32'h500; thread = 2'd2;
    @(posedge clk); #1;
    chk("rst_mid_w_req_before", w_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_w_req_async", w_req, 0);
    chk("rst_mid_outs_async", {data_o, w_addr, w_data_o, w_write, ack, ack_thread}, 0);
    f_enable = 1'b0; w_ack = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    acks = 0; rises = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) acks++;
      if (w_req) rises++;
    end
    w_ack = 1'b0;
    chk("rst_mid_no_ack", acks, 0);
    chk("rst_mid_no_w_req", rises, 0);

    // Back-to-back: f_enable held across two requests.
    @(negedge clk);
    f_enable = 1'b1; write_mode = 1'b0; addr = 32'h7F00; thread = 2'd2;
    acks = 0; rises = 0; prev = 1'b0; a1 = -1; a2 = -1; r2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      w_ack = w_req; w_data_i = 32'h1234_0000 + c;
      if (w_req && !prev) begin
        rises++;
        if (rises == 1) addr = 32'h7F04; else r2 = c;
      end
      prev = w_req;
      if (ack) begin
        acks++;
        if (acks == 1) a1 = c;
        else begin a2 = c; f_enable = 1'b0; end
      end
    end
    w_ack = 1'b0;
    chk("b2b_acks", acks, 2);
    chk("b2b_first_ack", a1, 2);
    chk("b2b_second_w_req", r2, a1 + 2);
    chk("b2b_second_ack", a2, 5);
    chk("b2b_w_addr", w_addr, 32'h7F04);
    chk("b2b_data_o", data_o, 32'h1234_0004);

    md = 32'h1234_0004;
    for (int j = 0; j < 4; j++) bv[j] = 1'b0;
    bv[2] = 1'b1; ba[2] = 32'h7F04; bd[2] = 32'h1234_0004;

    for (int i = 0; i < 60; i++) begin
      w    = ($urandom_range(0, 2) == 0);
      a    = 32'h100 + 32'(4 * $urandom_range(0, 3));
      d    = $urandom;
      t    = $urandom_range(0, 3);
      wt   = $urandom_range(0, 4);
      rd   = $urandom;
      hitm = BUF && !w && bv[t] && ba[t] == a;
      if (hitm) begin
        elat = 1;
        md   = bd[t];
      end else begin
        elat = wt + 2;
        if (!w) begin
          md = rd;
          if (BUF) begin bv[t] = 1'b1; ba[t] = a; bd[t] = rd; end
        end else if (BUF) begin
          for (int j = 0; j < 4; j++) if (ba[j] == a) bv[j] = 1'b0;
        end
      end
      run_txn(w, a, d, t, wt, rd, lat, busc, st, po, gdo, gthr);
      chk($sformatf("rnd%0d_lat", i), lat, elat);
      chk($sformatf("rnd%0d_data_o", i), gdo, md);
      chk($sformatf("rnd%0d_ack_thread", i), gthr, t);
      chk($sformatf("rnd%0d_bus_ok", i), {st, po, busc == (hitm ? 0 : wt + 1)}, 3'b111);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
